conv_ff_bank: RTL and testbench

CONV_FF_BANK -- requirements
Module: conv_ff_bank

---
 rtl/conv_ff_pkg.sv | 39 +++
 rtl/conv_ff_cell.sv | 58 +++++
 rtl/conv_ff_bank.sv | 65 ++++++
 tb/tb_conv_ff_bank.sv | 135 +++++++++++++
 4 files changed

// File: rtl/conv_ff_pkg.sv
// Shared mode encoding and per-bit next-state function for the convertible flip-flop bank.
package conv_ff_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_SR  = 2'b00;
  localparam mode_t MODE_JK  = 2'b01;
  localparam mode_t MODE_D   = 2'b10;
  localparam mode_t MODE_T   = 2'b11;
  localparam mode_t MODE_RST = MODE_JK;

  // SR 11 is illegal and holds; illegal-combination reporting is handled by the cell.
  function automatic logic ff_next(input mode_t mode, input logic q, input logic a, input logic b);
    logic nq;
    nq = q;
    case (mode)
      MODE_SR: begin
        case ({a, b})
          2'b10:   nq = 1'b1;
          2'b01:   nq = 1'b0;
          default: nq = q;
        endcase
      end
      MODE_JK: begin
        case ({a, b})
          2'b10:   nq = 1'b1;
          2'b01:   nq = 1'b0;
          2'b11:   nq = ~q;
          default: nq = q;
        endcase
      end
      MODE_D:  nq = a;
      MODE_T:  nq = q ^ a;
      default: nq = q;
    endcase
    return nq;
  endfunction

endpackage

// File: rtl/conv_ff_cell.sv
// One convertible flip-flop channel: next-state logic, q register and SR-illegal flag.
// Illegal detection is built only when CONV_FF_ILLEGAL_DET_EN is defined.
module conv_ff_cell
  import conv_ff_pkg::*;
#(
  parameter logic RST_BIT = 1'b0
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  en,
  input  mode_t mode,
  input  logic  a,
  input  logic  b,
  input  logic  err_clr,
  output logic  q,
  output logic  q_nxt,
  output logic  err
);

  // Next q, held when the bank is disabled
  always_comb begin
    q_nxt = q;
    if (en) begin
      q_nxt = ff_next(mode, q, a, b);
    end else begin
      q_nxt = q;
    end
  end

  // Channel state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= RST_BIT;
    end else begin
      q <= q_nxt;
    end
  end

`ifdef CONV_FF_ILLEGAL_DET_EN
  // Sticky illegal flag; a new detection beats a clear at the same edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else if (en && (mode == MODE_SR) && a && b) begin
      err <= 1'b1;
    end else if (err_clr) begin
      err <= 1'b0;
    end else begin
      err <= err;
    end
  end
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign err = 1'b0;
`endif

endmodule

// File: rtl/conv_ff_bank.sv
// Bank of WIDTH independent convertible flip-flops sharing one mode register.
// Optional SR-illegal detection is enabled by defining CONV_FF_ILLEGAL_DET_EN.
module conv_ff_bank
  import conv_ff_pkg::*;
#(
  parameter int               WIDTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode_ld,
  input  logic [1:0]       mode_in,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             err_clr,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic [1:0]       mode_q,
  output logic [WIDTH-1:0] err,
  output logic             chg
);

  logic [WIDTH-1:0] q_nxt;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    conv_ff_cell #(
      .RST_BIT (RST_VAL[i])
    ) u_cell (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .mode    (mode_q),
      .a       (a[i]),
      .b       (b[i]),
      .err_clr (err_clr),
      .q       (q[i]),
      .q_nxt   (q_nxt[i]),
      .err     (err[i])
    );
  end

  assign qb = ~q;

  // Mode register; the edge that loads it still evaluates with the old mode
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q <= MODE_RST;
    end else if (mode_ld) begin
      mode_q <= mode_in;
    end else begin
      mode_q <= mode_q;
    end
  end

  // Change pulse; q_nxt already equals q whenever en is low
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chg <= 1'b0;
    end else begin
      chg <= (q_nxt != q);
    end
  end

endmodule

// File: tb/tb_conv_ff_bank.sv
// Directed self-checking bench for conv_ff_bank; err expectations follow CONV_FF_ILLEGAL_DET_EN.
module tb_conv_ff_bank;

`ifdef CONV_FF_ILLEGAL_DET_EN
  localparam bit DET = 1'b1;
`else
  localparam bit DET = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       mode_ld;
  logic [1:0] mode_in;
  logic [3:0] a;
  logic [3:0] b;
  logic       err_clr;
  logic [3:0] q;
  logic [3:0] qb;
  logic [1:0] mode_q;
  logic [3:0] err;
  logic       chg;

  int n_checks = 0;
  int n_errors = 0;

  conv_ff_bank #(.WIDTH(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .mode_ld (mode_ld),
    .mode_in (mode_in),
    .a       (a),
    .b       (b),
    .err_clr (err_clr),
    .q       (q),
    .qb      (qb),
    .mode_q  (mode_q),
    .err     (err),
    .chg     (chg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic [3:0] eq, input logic [1:0] em,
                           input logic [3:0] ee, input logic ec);
    check({tag, ".q"},    {28'd0, q},      {28'd0, eq});
    check({tag, ".qb"},   {28'd0, qb},     {28'd0, ~eq});
    check({tag, ".mode"}, {30'd0, mode_q}, {30'd0, em});
    check({tag, ".err"},  {28'd0, err},    {28'd0, ee});
    check({tag, ".chg"},  {31'd0, chg},    {31'd0, ec});
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; mode_ld = 1'b0; mode_in = 2'b00;
    a = 4'b0000; b = 4'b0000; err_clr = 1'b0;
    #2;
    chk_state("reset", 4'b0000, 2'b01, 4'b0000, 1'b0);
    tick();
    rst = 1'b0;

    // JK set, then toggle
    en = 1'b1; a = 4'b0001; b = 4'b0000;
    tick(); chk_state("jk_set", 4'b0001, 2'b01, 4'b0000, 1'b1);
    a = 4'b0001; b = 4'b0001;
    tick(); chk_state("jk_tog1", 4'b0000, 2'b01, 4'b0000, 1'b1);
    tick(); chk_state("jk_tog2", 4'b0001, 2'b01, 4'b0000, 1'b1);
    tick(); chk_state("jk_tog3", 4'b0000, 2'b01, 4'b0000, 1'b1);

    // Mode load to D: loading edge still JK
    mode_ld = 1'b1; mode_in = 2'b10; a = 4'b1010; b = 4'b0000;
    tick(); chk_state("ld_d", 4'b1010, 2'b10, 4'b0000, 1'b1);
    mode_ld = 1'b0;
    tick(); chk_state("d_hold", 4'b1010, 2'b10, 4'b0000, 1'b0);
    // Load SR while in D: this edge must act as D (SR would give 1111)
    mode_ld = 1'b1; mode_in = 2'b00; a = 4'b0101;
    tick(); chk_state("ld_sr", 4'b0101, 2'b00, 4'b0000, 1'b1);
    mode_ld = 1'b0;

    // SR illegal and error flag handling
    a = 4'b0100; b = 4'b0100;
    tick(); chk_state("sr_ill", 4'b0101, 2'b00, DET ? 4'b0100 : 4'b0000, 1'b0);
    err_clr = 1'b1; a = 4'b0000; b = 4'b0000;
    tick(); chk_state("err_clr", 4'b0101, 2'b00, 4'b0000, 1'b0);
    a = 4'b0100; b = 4'b0100;
    tick(); chk_state("set_wins", 4'b0101, 2'b00, DET ? 4'b0100 : 4'b0000, 1'b0);
    err_clr = 1'b0; a = 4'b1000; b = 4'b0001;
    tick(); chk_state("sr_sr", 4'b1100, 2'b00, DET ? 4'b0100 : 4'b0000, 1'b1);
    a = 4'b1111; b = 4'b1111;
    tick(); chk_state("sr_all11", 4'b1100, 2'b00, DET ? 4'b1111 : 4'b0000, 1'b0);

    // T mode, then disable
    mode_ld = 1'b1; mode_in = 2'b11; a = 4'b0000; b = 4'b0000;
    tick(); chk_state("ld_t", 4'b1100, 2'b11, DET ? 4'b1111 : 4'b0000, 1'b0);
    mode_ld = 1'b0; a = 4'b1111;
    tick(); chk_state("t1", 4'b0011, 2'b11, DET ? 4'b1111 : 4'b0000, 1'b1);
    tick(); chk_state("t2", 4'b1100, 2'b11, DET ? 4'b1111 : 4'b0000, 1'b1);
    tick(); chk_state("t3", 4'b0011, 2'b11, DET ? 4'b1111 : 4'b0000, 1'b1);
    en = 1'b0;
    tick(); chk_state("dis1", 4'b0011, 2'b11, DET ? 4'b1111 : 4'b0000, 1'b0);
    mode_ld = 1'b1; mode_in = 2'b01;
    tick(); chk_state("dis_ld", 4'b0011, 2'b01, DET ? 4'b1111 : 4'b0000, 1'b0);

    // JK set to 1111, then asynchronous reset between edges
    mode_ld = 1'b0; en = 1'b1; a = 4'b1100; b = 4'b0000;
    tick(); chk_state("jk_fill", 4'b1111, 2'b01, DET ? 4'b1111 : 4'b0000, 1'b1);
    #2 rst = 1'b1;
    #1 chk_state("async_rst", 4'b0000, 2'b01, 4'b0000, 1'b0);
    a = 4'b1111; b = 4'b0000; mode_ld = 1'b1; mode_in = 2'b11;
    tick(); chk_state("rst_hold", 4'b0000, 2'b01, 4'b0000, 1'b0);
    rst = 1'b0; mode_ld = 1'b0; a = 4'b0011; b = 4'b0001;

    // First edges after reset evaluate as JK
    tick(); chk_state("post_rst1", 4'b0011, 2'b01, 4'b0000, 1'b1);
    a = 4'b0001; b = 4'b0011;
    tick(); chk_state("post_rst2", 4'b0000, 2'b01, 4'b0000, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
